// File: rtl/i2c_pkg.sv
// Shared definitions for the parametrised I2C SDA shift engine: state
// encoding, SDA drive levels and the wire-position to bit-index mapping.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RX     = 3'd1,
        RX_ACK = 3'd2,
        TX     = 3'd3,
        TX_ACK = 3'd4
    } state_e;

    localparam logic SDA_RELEASE   = 1'b1;
    localparam logic SDA_DRIVE_LOW = 1'b0;

    // Word bit that travels on the wire at serial position n.
    function automatic int bit_pos(input int n, input int width, input bit msb_first);
        return msb_first ? (width - 1 - n) : n;
    endfunction

endpackage

// File: rtl/i2c_shift_register_param.sv
// Bidirectional SDA shift engine with configurable word width and bit order,
// ACK-slot handling in both directions and a hold register that lets a
// second transmit word follow the ACK slot with no idle bit period.
// All state moves on the falling edge of SCL.
module i2c_shift_register_param
    import i2c_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             SCL,
    input  logic             reset,
    input  logic             SDAIn,
    output logic             SDAOut,
    input  logic [WIDTH-1:0] shiftRegIn,
    output logic [WIDTH-1:0] shiftRegOut,
    input  logic             shiftIn,
    input  logic             shiftOut,
    input  logic             loadShift,
    input  logic             ackEn,
    output logic             byteDone,
    output logic             ackReceived,
    output logic             holdFull,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] POS0 = IW'(bit_pos(0, WIDTH, MSB_FIRST));

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] rx_word_q, rx_word_d;
    logic             sda_q, sda_d;
    logic             byte_done_q, byte_done_d;
    logic             ack_q, ack_d;
    logic [IW-1:0]    cur_idx;

    // Word bit addressed by the current serial position.
    assign cur_idx = IW'(bit_pos(int'(count_q), WIDTH, MSB_FIRST));

    // Next-state logic: transfer sequencing, bit capture/drive and hold register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_word_d   = rx_word_q;
        sda_d       = sda_q;
        byte_done_d = 1'b0;
        ack_d       = ack_q;

        unique case (state_q)
            IDLE: begin
                sda_d = SDA_RELEASE;
                if (loadShift) shreg_d = shiftRegIn;
                if (shiftIn) begin
                    shreg_d[POS0] = SDAIn;
                    count_d       = CW'(1);
                    state_d       = RX;
                end else if (shiftOut) begin
                    // Transmit the word as it stands after a same-edge load.
                    sda_d   = shreg_d[POS0];
                    count_d = CW'(1);
                    state_d = TX;
                end
            end
            RX: begin
                shreg_d[cur_idx] = SDAIn;
                if (count_q == CW'(WIDTH - 1)) begin
                    rx_word_d   = shreg_d;
                    byte_done_d = 1'b1;
                    count_d     = '0;
                    if (ackEn) begin
                        sda_d   = SDA_DRIVE_LOW;
                        state_d = RX_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            RX_ACK: begin
                sda_d   = SDA_RELEASE;
                state_d = IDLE;
            end
            TX: begin
                if (count_q == CW'(WIDTH)) begin
                    // Let go of SDA so the master can drive its ACK.
                    sda_d   = SDA_RELEASE;
                    count_d = '0;
                    state_d = TX_ACK;
                end else begin
                    sda_d   = shreg_q[cur_idx];
                    count_d = count_q + CW'(1);
                end
            end
            TX_ACK: begin
                ack_d       = ~SDAIn;
                byte_done_d = 1'b1;
                if (!SDAIn && shiftOut && hold_full_q) begin
                    // Chain the held word straight into the next bit period.
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    sda_d       = hold_q[POS0];
                    count_d     = CW'(1);
                    state_d     = TX;
                end else begin
                    sda_d   = SDA_RELEASE;
                    state_d = IDLE;
                end
            end
            default: begin
                sda_d   = SDA_RELEASE;
                count_d = '0;
                state_d = IDLE;
            end
        endcase

        // A load while busy parks the word in hold; it wins over a same-edge chain.
        if (loadShift && (state_q != IDLE)) begin
            hold_d      = shiftRegIn;
            hold_full_d = 1'b1;
        end
    end

    // State registers with synchronous reset on the falling SCL edge.
    always_ff @(negedge SCL) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_word_q   <= '0;
            sda_q       <= SDA_RELEASE;
            byte_done_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same old values.
            state_q     <= state_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_word_q   <= rx_word_d;
            sda_q       <= sda_d;
            byte_done_q <= byte_done_d;
            ack_q       <= ack_d;
        end
    end

    assign SDAOut      = sda_q;
    assign shiftRegOut = rx_word_q;
    assign byteDone    = byte_done_q;
    assign ackReceived = ack_q;
    assign holdFull    = hold_full_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_shift_register_param.sv
// Scoreboard bench for i2c_shift_register_param: one 8-bit MSB-first
// instance and one 4-bit LSB-first instance. Stimulus tasks drive one SCL
// period at a time and queue the expected outputs; a monitor samples shortly
// after each falling edge and compares against the queue head.
module tb_i2c_shift_register_param;

    logic SCL = 1'b1;
    always #5 SCL = ~SCL;

    // 8-bit, MSB-first instance
    logic       a_rst = 1'b1, a_sdain = 1'b1, a_shin = 1'b0, a_shout = 1'b0;
    logic       a_load = 1'b0, a_acken = 1'b1;
    logic [7:0] a_din = 8'h00;
    logic       a_sda, a_bd, a_ack, a_hf, a_busy;
    logic [7:0] a_rxw;

    // 4-bit, LSB-first instance
    logic       b_rst = 1'b1, b_sdain = 1'b1, b_shin = 1'b0, b_shout = 1'b0;
    logic       b_load = 1'b0, b_acken = 1'b0;
    logic [3:0] b_din = 4'h0;
    logic       b_sda, b_bd, b_ack, b_hf, b_busy;
    logic [3:0] b_rxw;

    i2c_shift_register_param #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .SCL(SCL), .reset(a_rst), .SDAIn(a_sdain), .SDAOut(a_sda),
        .shiftRegIn(a_din), .shiftRegOut(a_rxw), .shiftIn(a_shin),
        .shiftOut(a_shout), .loadShift(a_load), .ackEn(a_acken),
        .byteDone(a_bd), .ackReceived(a_ack), .holdFull(a_hf), .busy(a_busy)
    );

    i2c_shift_register_param #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .SCL(SCL), .reset(b_rst), .SDAIn(b_sdain), .SDAOut(b_sda),
        .shiftRegIn(b_din), .shiftRegOut(b_rxw), .shiftIn(b_shin),
        .shiftOut(b_shout), .loadShift(b_load), .ackEn(b_acken),
        .byteDone(b_bd), .ackReceived(b_ack), .holdFull(b_hf), .busy(b_busy)
    );

    // Expected outputs after one falling edge; -1 marks a don't-care field.
    typedef struct {
        int    dut;
        string tag;
        int    sda, bd, busy, hf, ack, rx;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int dut, input string tag,
                        input int sda, input int bd, input int busy,
                        input int hf, input int ack, input int rx);
        exp_t e;
        e.dut = dut; e.tag = tag;
        e.sda = sda; e.bd = bd; e.busy = busy; e.hf = hf; e.ack = ack; e.rx = rx;
        sb.push_back(e);
    endtask

    // One SCL period on instance A: drive inputs, queue expected outputs.
    task automatic ea(input logic rst, input logic sdain, input logic shin,
                      input logic shout, input logic load, input logic [7:0] din,
                      input string tag, input int sda, input int bd, input int busy,
                      input int hf, input int ack, input int rx);
        @(posedge SCL);
        a_rst = rst; a_sdain = sdain; a_shin = shin; a_shout = shout;
        a_load = load; a_din = din;
        push(0, tag, sda, bd, busy, hf, ack, rx);
    endtask

    // One SCL period on instance B.
    task automatic eb(input logic rst, input logic sdain, input logic shin,
                      input logic shout, input logic load, input logic [3:0] din,
                      input string tag, input int sda, input int bd, input int busy,
                      input int hf, input int ack, input int rx);
        @(posedge SCL);
        b_rst = rst; b_sdain = sdain; b_shin = shin; b_shout = shout;
        b_load = load; b_din = din;
        push(1, tag, sda, bd, busy, hf, ack, rx);
    endtask

    // Bits 6..0 of an MSB-first word plus the release edge on instance A.
    // An optional load on the first of these edges fills the hold register.
    task automatic tx_body_a(input logic [7:0] w, input string tag, input int hf,
                             input logic shout, input logic load, input logic [7:0] din);
        for (int i = 1; i < 8; i++) begin
            ea(1'b0, 1'b1, 1'b0, shout, load && (i == 1), din,
               $sformatf("%s_bit%0d", tag, i), int'(w[7-i]), 0, 1, hf, -1, -1);
        end
        ea(1'b0, 1'b1, 1'b0, shout, 1'b0, 8'h00, {tag, "_rel"}, 1, 0, 1, hf, -1, -1);
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each edge.
    initial begin
        forever begin
            @(negedge SCL);
            #2;
            if (sb.size() > 0) begin
                exp_t e;
                int   sda, bd, busy, hf, ack, rx;
                e = sb.pop_front();
                if (e.dut == 0) begin
                    sda = int'(a_sda); bd = int'(a_bd); busy = int'(a_busy);
                    hf = int'(a_hf); ack = int'(a_ack); rx = int'(a_rxw);
                end else begin
                    sda = int'(b_sda); bd = int'(b_bd); busy = int'(b_busy);
                    hf = int'(b_hf); ack = int'(b_ack); rx = int'(b_rxw);
                end
                if (e.sda  >= 0) check({e.tag, ".SDAOut"},      sda,  e.sda);
                if (e.bd   >= 0) check({e.tag, ".byteDone"},    bd,   e.bd);
                if (e.busy >= 0) check({e.tag, ".busy"},        busy, e.busy);
                if (e.hf   >= 0) check({e.tag, ".holdFull"},    hf,   e.hf);
                if (e.ack  >= 0) check({e.tag, ".ackReceived"}, ack,  e.ack);
                if (e.rx   >= 0) check({e.tag, ".shiftRegOut"}, rx,   e.rx);
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "simulation time bound exceeded");
    end

    // Stimulus
    initial begin
        logic [7:0] rxb;

        // Reset state
        ea(1, 1, 0, 0, 0, 8'h00, "rst0", 1, 0, 0, 0, 0, 0);
        ea(1, 1, 0, 0, 0, 8'h00, "rst1", 1, 0, 0, 0, 0, 0);

        // RX 0xA5 with ACK; shiftIn held high mid-word must be ignored
        rxb = 8'hA5;
        for (int i = 0; i < 7; i++)
            ea(0, rxb[7-i], 1, 0, 0, 8'h00, $sformatf("rx_bit%0d", i), 1, 0, 1, 0, 0, 0);
        ea(0, rxb[0], 1, 0, 0, 8'h00, "rx_bit7", 0, 1, 1, 0, 0, 8'hA5);
        ea(0, 1, 0, 0, 0, 8'h00, "rx_ackslot", 1, 0, 0, 0, 0, 8'hA5);
        ea(0, 1, 0, 0, 0, 8'h00, "rx_idle", 1, 0, 0, 0, 0, 8'hA5);

        // TX 0x3C with same-edge load, master ACK
        ea(0, 1, 0, 1, 1, 8'h3C, "tx1_start", 0, 0, 1, 0, 0, 8'hA5);
        tx_body_a(8'h3C, "tx1", 0, 1'b0, 1'b0, 8'h00);
        ea(0, 0, 0, 0, 0, 8'h00, "tx1_ack", 1, 1, 0, 0, 1, 8'hA5);

        // Chained TX: 0x55 then held 0xF0 with no gap edge
        ea(0, 1, 0, 1, 1, 8'h55, "ch_start", 0, 0, 1, 0, 1, 8'hA5);
        tx_body_a(8'h55, "ch1", 1, 1'b1, 1'b1, 8'hF0);
        ea(0, 0, 0, 1, 0, 8'h00, "ch_ack", 1, 1, 1, 0, 1, 8'hA5);
        tx_body_a(8'hF0, "ch2", 0, 1'b0, 1'b0, 8'h00);
        ea(0, 0, 0, 0, 0, 8'h00, "ch2_ack", 1, 1, 0, 0, 1, 8'hA5);

        // NACK on 0x81 with hold loaded (0x77): back to IDLE, hold kept
        ea(0, 1, 0, 1, 1, 8'h81, "nk_start", 1, 0, 1, 0, 1, 8'hA5);
        tx_body_a(8'h81, "nk", 1, 1'b1, 1'b1, 8'h77);
        ea(0, 1, 0, 1, 0, 8'h00, "nk_ack", 1, 1, 0, 1, 0, 8'hA5);

        // Load in IDLE goes to the shift register; load on the chaining edge
        // refills hold while the old hold word (0x77) is sent, then 0xAA chains
        ea(0, 1, 0, 1, 1, 8'hC3, "lc_start", 1, 0, 1, 1, 0, 8'hA5);
        tx_body_a(8'hC3, "lc1", 1, 1'b1, 1'b0, 8'h00);
        ea(0, 0, 0, 1, 1, 8'hAA, "lc1_ack", 0, 1, 1, 1, 1, 8'hA5);
        tx_body_a(8'h77, "lc2", 1, 1'b1, 1'b0, 8'h00);
        ea(0, 0, 0, 1, 0, 8'h00, "lc2_ack", 1, 1, 1, 0, 1, 8'hA5);
        tx_body_a(8'hAA, "lc3", 0, 1'b0, 1'b0, 8'h00);
        ea(0, 0, 0, 0, 0, 8'h00, "lc3_ack", 1, 1, 0, 0, 1, 8'hA5);

        // Reset at bit 4 of TX 0x00 with hold occupied
        ea(0, 1, 0, 1, 1, 8'h00, "rm_bit0", 0, 0, 1, 0, 1, 8'hA5);
        ea(0, 1, 0, 0, 1, 8'h5A, "rm_bit1", 0, 0, 1, 1, 1, 8'hA5);
        ea(0, 1, 0, 0, 0, 8'h00, "rm_bit2", 0, 0, 1, 1, 1, 8'hA5);
        ea(0, 1, 0, 0, 0, 8'h00, "rm_bit3", 0, 0, 1, 1, 1, 8'hA5);
        ea(1, 1, 0, 0, 0, 8'h00, "rm_reset", 1, 0, 0, 0, 0, 0);
        ea(0, 1, 0, 0, 0, 8'h00, "rm_idle", 1, 0, 0, 0, 0, 0);
        // A fresh transfer afterwards shows the bit counter restarted
        ea(0, 1, 0, 1, 1, 8'h3C, "rt_start", 0, 0, 1, 0, 0, 0);
        tx_body_a(8'h3C, "rt", 0, 1'b0, 1'b0, 8'h00);
        ea(0, 1, 0, 0, 0, 8'h00, "rt_nack", 1, 1, 0, 0, 0, 0);

        // Instance B: WIDTH=4, LSB first
        eb(1, 1, 0, 0, 0, 4'h0, "b_rst", 1, 0, 0, 0, 0, 0);
        eb(0, 1, 1, 0, 0, 4'h0, "b_rx0", 1, 0, 1, 0, 0, 0);
        eb(0, 1, 0, 0, 0, 4'h0, "b_rx1", 1, 0, 1, 0, 0, 0);
        eb(0, 0, 0, 0, 0, 4'h0, "b_rx2", 1, 0, 1, 0, 0, 0);
        eb(0, 0, 0, 0, 0, 4'h0, "b_rx3", 1, 1, 0, 0, 0, 3);
        eb(0, 1, 0, 0, 0, 4'h0, "b_rx_after", 1, 0, 0, 0, 0, 3);
        eb(0, 1, 0, 1, 1, 4'hA, "b_tx0", 0, 0, 1, 0, 0, 3);
        eb(0, 1, 0, 0, 0, 4'h0, "b_tx1", 1, 0, 1, 0, 0, 3);
        eb(0, 1, 0, 0, 0, 4'h0, "b_tx2", 0, 0, 1, 0, 0, 3);
        eb(0, 1, 0, 0, 0, 4'h0, "b_tx3", 1, 0, 1, 0, 0, 3);
        eb(0, 1, 0, 0, 0, 4'h0, "b_tx_rel", 1, 0, 1, 0, 0, 3);
        eb(0, 0, 0, 0, 0, 4'h0, "b_tx_ack", 1, 1, 0, 0, 1, 3);

        repeat (3) @(posedge SCL);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_shift_register_param.md
Name: i2c_shift_register_param

Overview:
Parametrised successor to the I2C byte shifter. It is a bidirectional SDA shift engine with a configurable word width and bit order, plus ACK-slot handling in both directions. A hold register allows back-to-back transmit bytes without an idle bit period. It sits between the I2C slave control FSM and the flash memory array data path.

Parameters:
WIDTH, 8, bits per transfer word (2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 on the wire first; 0 = bit 0 first

Ports:
SCL  input  1  sole clock; all state updates on falling edge of SCL
reset  input  1  synchronous, active-high; sampled on falling SCL edge
SDAIn  input  1  sampled SDA line
SDAOut  output  1  open-drain drive value; 1 = release, 0 = pull low
shiftRegIn  input  WIDTH  word to transmit
shiftRegOut  output  WIDTH  last received word
shiftIn  input  1  start receive; sampled only in IDLE
shiftOut  input  1  start transmit; sampled only in IDLE and TX_ACK
loadShift  input  1  load shiftRegIn (to shift register if IDLE, else to hold register)
ackEn  input  1  drive ACK after a received word
byteDone  output  1  one-cycle pulse at end of word (RX: word complete; TX: ACK slot sampled)
ackReceived  output  1  1 = master ACKed last transmitted word; held until next TX_ACK
holdFull  output  1  hold register occupied
busy  output  1  state != IDLE

Behaviour:
- Reset values: state IDLE; count 0; register, hold, and shiftRegOut 0; holdFull 0; SDAOut 1; byteDone 0; ackReceived 0. Reset mid-byte aborts immediately; SDAOut is released on that edge.
- Bit index for position n: MSB_FIRST ? WIDTH-1-n : n. count width is clog2(WIDTH+1).
- byteDone defaults to 0 every edge unless set below.
- IDLE:
  - Priority: shiftIn > shiftOut. loadShift is applied before shiftOut on the same edge.
  - loadShift: register <= shiftRegIn.
  - shiftIn: capture SDAIn into position 0; count <= 1; go to RX.
  - shiftOut: SDAOut <= position 0 of the (possibly just-loaded) word; count <= 1; go to TX.
  - Otherwise SDAOut stays 1.
- RX:
  - Capture SDAIn into position count.
  - If count == WIDTH-1: shiftRegOut <= complete word (including this bit); byteDone <= 1; count <= 0. If ackEn, SDAOut <= 0 and go to RX_ACK; else go to IDLE.
  - Otherwise count++.
- RX_ACK: SDAOut <= 1; go to IDLE. The next byte's first bit arrives on the following edge, so no bit is lost.
- TX:
  - If count < WIDTH: SDAOut <= position count; count++.
  - If count == WIDTH: SDAOut <= 1 (release for master ACK); count <= 0; go to TX_ACK.
- TX_ACK:
  - ackReceived <= ~SDAIn; byteDone <= 1.
  - If SDAIn == 0 && shiftOut && holdFull: register <= hold; holdFull <= 0; SDAOut <= position 0 of hold; count <= 1; go to TX (chained byte, zero gap).
  - Else go to IDLE with SDAOut = 1. A NACK leaves holdFull untouched.
- loadShift while busy: hold <= shiftRegIn; holdFull <= 1. A load when already full overwrites hold.
- loadShift in TX_ACK on the chaining edge: the old hold value is chained; the new value goes into hold and holdFull stays 1.
- shiftIn/shiftOut mid-word are ignored; a word always completes unless reset.
- shiftRegOut changes only on RX word completion.
- Latency: RX word visible on shiftRegOut at the edge that samples the last bit. TX takes WIDTH+2 edges from start to byteDone.

Decomposition:
- Shared package i2c_pkg holds:
  - state typedef (IDLE, RX, RX_ACK, TX, TX_ACK), 3-bit encoding;
  - constants SDA_RELEASE = 1 and SDA_DRIVE_LOW = 0;
  - function bit_pos(n, WIDTH, MSB_FIRST).
- No sub-module; the hold register stays inline.

Test Plan:
- RX, WIDTH=8, MSB_FIRST=1, ackEn=1: shiftIn in IDLE, SDAIn serial 1,0,1,0,0,1,0,1 -> shiftRegOut=0xA5 and byteDone pulse on the 8th edge; SDAOut=0 for exactly the next edge period, then 1; state IDLE.
- TX with load: loadShift+shiftOut in IDLE with shiftRegIn=0x3C -> SDAOut sequence 0,0,1,1,1,1,0,0, then 1. Master drives SDAIn=0 in the ACK slot -> ackReceived=1, byteDone pulse, busy=0.
- Chained TX: during TX load 0xF0 (holdFull=1); shiftOut held; ACK=0 -> no gap edge, SDAOut 1,1,1,1,0,0,0,0 follows immediately; holdFull=0.
- NACK: TX 0x81 with hold loaded and SDAIn=1 in the ACK slot -> ackReceived=0, IDLE, holdFull stays 1.
- MSB_FIRST=0, WIDTH=4: receive serial 1,1,0,0 with ackEn=0 -> shiftRegOut=0x3; no SDAOut low pulse.
- Reset at bit 4 of TX 0x00 -> next edge SDAOut=1, busy=0, count=0, holdFull=0, shiftRegOut=0.
